// File: rtl/anomaly_pkg.sv
// Shared types for the anomaly alarm path: aggregator FSM states and
// the alarm-entry counter width.
package anomaly_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        MONITOR = 2'd1,
        ALARM   = 2'd2,
        COOL    = 2'd3
    } state_t;

    localparam int unsigned TOTAL_W = 16;

endpackage

// File: rtl/anomaly_window_counter.sv
// Sliding window of the last WINDOW valid anomaly decisions with a
// running anomalous-sample count and a fill tracker.
module anomaly_window_counter #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CW     = $clog2(WINDOW + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          anomaly_in,
    input  logic          anomaly_valid,
    output logic [CW-1:0] count,
    output logic          window_full,
    output logic [CW-1:0] count_next_c,
    output logic          fill_done_c
);

    logic [WINDOW-1:0] win;
    logic [CW-1:0]     fill;

    // The bit leaving the window only counts once the window has been filled.
    always_comb begin
        count_next_c = count;
        fill_done_c  = 1'b0;
        if (anomaly_valid) begin
            count_next_c = count + CW'(anomaly_in) - CW'(window_full & win[WINDOW-1]);
            fill_done_c  = !window_full && (fill == CW'(WINDOW - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win         <= '0;
            fill        <= '0;
            count       <= '0;
            window_full <= 1'b0;
        end else if (anomaly_valid) begin
            win   <= {win[WINDOW-2:0], anomaly_in};
            count <= count_next_c;
            if (!window_full) begin
                fill <= fill + CW'(1);
            end
            if (fill_done_c) begin
                window_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/anomaly_alarm_aggregator.sv
// Windowed anomaly-count alarm: latched alarm with entry irq pulse, ack,
// and a sample-based cooldown before re-arming.
import anomaly_pkg::*;

module anomaly_alarm_aggregator #(
    parameter int unsigned WINDOW   = 16,
    parameter int unsigned THRESH   = 4,
    parameter int unsigned COOLDOWN = 8,
    parameter int unsigned CW       = $clog2(WINDOW + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               anomaly_in,
    input  logic               anomaly_valid,
    input  logic               alarm_ack,
    output logic               alarm,
    output logic               alarm_irq,
    output logic [CW-1:0]      anom_count,
    output logic               window_full,
    output logic [TOTAL_W-1:0] alarm_total
);

    if (WINDOW < 2 || WINDOW > 256) begin : g_bad_window
        $error("WINDOW must be in 2..256");
    end
    if (THRESH < 1 || THRESH > WINDOW) begin : g_bad_thresh
        $error("THRESH must be in 1..WINDOW");
    end
    if (COOLDOWN > 255) begin : g_bad_cooldown
        $error("COOLDOWN must be in 0..255");
    end
    if (CW != $clog2(WINDOW + 1)) begin : g_bad_cw
        $error("CW is derived from WINDOW and must not be overridden");
    end

    state_t        state;
    logic [7:0]    cool;
    logic [CW-1:0] count_next_c;
    logic          fill_done_c;
    logic          over_c;
    logic          enter_c;

    anomaly_window_counter #(
        .WINDOW (WINDOW),
        .CW     (CW)
    ) u_window (
        .clk          (clk),
        .reset        (reset),
        .anomaly_in   (anomaly_in),
        .anomaly_valid(anomaly_valid),
        .count        (anom_count),
        .window_full  (window_full),
        .count_next_c (count_next_c),
        .fill_done_c  (fill_done_c)
    );

    // Triggering is only possible on the filling sample or on a valid sample while monitoring.
    always_comb begin
        over_c  = (count_next_c >= CW'(THRESH));
        enter_c = 1'b0;
        if (state == FILL) begin
            enter_c = fill_done_c && over_c;
        end else if (state == MONITOR) begin
            enter_c = anomaly_valid && over_c;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= FILL;
            cool        <= '0;
            alarm       <= 1'b0;
            alarm_irq   <= 1'b0;
            alarm_total <= '0;
        end else begin
            alarm_irq <= 1'b0;
            if (enter_c) begin
                state     <= ALARM;
                alarm     <= 1'b1;
                alarm_irq <= 1'b1;
                if (alarm_total != '1) begin
                    alarm_total <= alarm_total + TOTAL_W'(1);
                end
            end else begin
                unique case (state)
                    FILL: begin
                        if (fill_done_c) begin
                            state <= MONITOR;
                        end
                    end
                    MONITOR: ;
                    ALARM: begin
                        if (alarm_ack) begin
                            alarm <= 1'b0;
                            cool  <= 8'(COOLDOWN);
                            state <= (COOLDOWN == 0) ? MONITOR : COOL;
                        end
                    end
                    COOL: begin
                        // Re-arm after COOLDOWN valid samples have gone by.
                        if (anomaly_valid) begin
                            cool <= cool - 8'd1;
                            if (cool <= 8'd1) begin
                                state <= MONITOR;
                            end
                        end
                    end
                    default: state <= FILL;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_anomaly_alarm_aggregator.sv
// Directed bench for anomaly_alarm_aggregator with a sample-history model
// checked every cycle, plus literal expectations at key points.
module tb_anomaly_alarm_aggregator;

    localparam int unsigned WINDOW   = 16;
    localparam int unsigned THRESH   = 4;
    localparam int unsigned COOLDOWN = 8;
    localparam int unsigned CW       = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          anomaly_in;
    logic          anomaly_valid;
    logic          alarm_ack;
    logic          alarm;
    logic          alarm_irq;
    logic [CW-1:0] anom_count;
    logic          window_full;
    logic [15:0]   alarm_total;

    anomaly_alarm_aggregator #(
        .WINDOW  (WINDOW),
        .THRESH  (THRESH),
        .COOLDOWN(COOLDOWN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .anomaly_in   (anomaly_in),
        .anomaly_valid(anomaly_valid),
        .alarm_ack    (alarm_ack),
        .alarm        (alarm),
        .alarm_irq    (alarm_irq),
        .anom_count   (anom_count),
        .window_full  (window_full),
        .alarm_total  (alarm_total)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Model: history of the most recent valid samples plus alarm bookkeeping.
    bit hist[$];
    int m_seen, m_count, m_alarm, m_irq, m_total, m_cool;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        m_seen  = 0;
        m_count = 0;
        m_alarm = 0;
        m_irq   = 0;
        m_total = 0;
        m_cool  = 0;
    endfunction

    function automatic void model_step(input bit v, input bit a, input bit k);
        int pa;
        int pc;
        pa    = m_alarm;
        pc    = m_cool;
        m_irq = 0;
        if (v) begin
            hist.push_back(a);
            if (hist.size() > WINDOW) void'(hist.pop_front());
            m_seen++;
            m_count = 0;
            foreach (hist[i]) m_count += int'(hist[i]);
        end
        if (pa != 0) begin
            if (k) begin
                m_alarm = 0;
                m_cool  = COOLDOWN;
            end
        end else if (pc > 0) begin
            if (v) m_cool--;
        end else if (v && m_seen >= WINDOW && m_count >= THRESH) begin
            m_alarm = 1;
            m_irq   = 1;
            if (m_total < 65535) m_total++;
        end
    endfunction

    task automatic cycle(input bit v, input bit a, input bit k);
        anomaly_valid = v;
        anomaly_in    = a;
        alarm_ack     = k;
        @(posedge clk);
        #1;
        model_step(v, a, k);
    endtask

    task automatic feed(input int n, input bit a);
        for (int i = 0; i < n; i++) cycle(1'b1, a, 1'b0);
    endtask

    task automatic lit_zero(input string tag);
        chk({tag, "_alarm"}, int'(alarm), 0);
        chk({tag, "_irq"}, int'(alarm_irq), 0);
        chk({tag, "_count"}, int'(anom_count), 0);
        chk({tag, "_full"}, int'(window_full), 0);
        chk({tag, "_total"}, int'(alarm_total), 0);
    endtask

    // Asynchronous reset applied away from any clock edge.
    task automatic do_reset(input string tag);
        anomaly_valid = 1'b0;
        anomaly_in    = 1'b0;
        alarm_ack     = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        lit_zero(tag);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("alarm", int'(alarm), m_alarm);
            chk("alarm_irq", int'(alarm_irq), m_irq);
            chk("anom_count", int'(anom_count), m_count);
            chk("window_full", int'(window_full), (m_seen >= WINDOW) ? 1 : 0);
            chk("alarm_total", int'(alarm_total), m_total);
        end
    end

    initial begin
        logic [31:0] pat;
        pat           = 32'hB38E_5C71;
        reset         = 1'b1;
        anomaly_valid = 1'b0;
        anomaly_in    = 1'b0;
        alarm_ack     = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        lit_zero("por");
        reset  = 1'b0;
        chk_en = 1'b1;

        // All-anomalous fill: alarm only on the filling sample.
        feed(15, 1'b1);
        chk("fill15_alarm", int'(alarm), 0);
        chk("fill15_full", int'(window_full), 0);
        chk("fill15_count", int'(anom_count), 15);
        feed(1, 1'b1);
        chk("fill16_alarm", int'(alarm), 1);
        chk("fill16_irq", int'(alarm_irq), 1);
        chk("fill16_count", int'(anom_count), 16);
        chk("fill16_full", int'(window_full), 1);
        chk("fill16_total", int'(alarm_total), 1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("irq_one_cycle", int'(alarm_irq), 0);
        chk("alarm_held", int'(alarm), 1);

        // Ack, cooldown of 8 samples, then re-alarm with ones still in window.
        cycle(1'b0, 1'b0, 1'b1);
        chk("ack_drop", int'(alarm), 0);
        feed(8, 1'b0);
        chk("cool_alarm", int'(alarm), 0);
        chk("cool_count", int'(anom_count), 8);
        feed(1, 1'b0);
        chk("rearm_alarm", int'(alarm), 1);
        chk("rearm_irq", int'(alarm_irq), 1);
        chk("rearm_count", int'(anom_count), 7);
        chk("rearm_total", int'(alarm_total), 2);

        // Alternating pattern after an all-zero fill.
        do_reset("rst_a");
        feed(16, 1'b0);
        for (int i = 0; i < 6; i++) feed(1, (i % 2 == 0));
        chk("alt6_alarm", int'(alarm), 0);
        chk("alt6_count", int'(anom_count), 3);
        feed(1, 1'b1);
        chk("alt7_alarm", int'(alarm), 1);
        chk("alt7_count", int'(anom_count), 4);
        cycle(1'b0, 1'b0, 1'b1);
        feed(8, 1'b0);
        feed(1, 1'b0);
        chk("alt_rearm", int'(alarm), 1);
        cycle(1'b1, 1'b0, 1'b1);
        feed(17, 1'b0);
        chk("alt_quiet", int'(alarm), 0);
        chk("alt_quiet_count", int'(anom_count), 0);

        // Window slide: four leading ones leave one per sample.
        do_reset("rst_b");
        feed(4, 1'b1);
        feed(12, 1'b0);
        chk("slide_count4", int'(anom_count), 4);
        for (int i = 3; i >= 0; i--) begin
            feed(1, 1'b0);
            chk("slide_count", int'(anom_count), i);
        end

        // Reset mid-alarm.
        chk("pre_rst_alarm", int'(alarm), 1);
        do_reset("rst_alarm");

        // Ack held in monitor, toggling input with gaps.
        feed(16, 1'b0);
        for (int i = 0; i < 48; i++) begin
            cycle((i % 5) != 3, pat[i % 32], (i % 7 == 0) || (i >= 20 && i < 24));
        end

        // Reset mid-cooldown, then behaviour matches power-up.
        do_reset("rst_c");
        feed(16, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        feed(2, 1'b0);
        do_reset("rst_cool");
        feed(15, 1'b1);
        chk("again15_alarm", int'(alarm), 0);
        feed(1, 1'b1);
        chk("again16_alarm", int'(alarm), 1);
        chk("again16_total", int'(alarm_total), 1);
        cycle(1'b0, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
